datamem_arbiter: RTL

Sequences and shares the single data memory between two requesters: the pipeline MEM stage (port cpu) and a debug/loader port (port dbg). It runs a fixed-latency access FSM with round-robin grant and aligned-access checking. While a CPU access is pending or in flight, it drives cpu_stall so the pipeline can freeze its stage registers. The memory interface mirrors datamem: 64-bit address and data, write enable, and transfer size fixed at 8 bytes.

---
 rtl/datamem_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/datamem_arbiter.sv
// Two-port (cpu / dbg) arbiter in front of a single fixed-latency data memory.
// Round-robin grant, aligned-access checking, and a pipeline stall for the cpu port.
module datamem_arbiter #(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [63:0] cpu_addr,
  input  logic [63:0] cpu_wdata,
  output logic [63:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_err,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [63:0] dbg_addr,
  input  logic [63:0] dbg_wdata,
  output logic [63:0] dbg_rdata,
  output logic        dbg_ack,
  output logic        dbg_err,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_we,
  output logic [3:0]  mem_xfer_size,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             r_state;
  logic               r_grant;
  logic               r_last_grant;
  logic               r_we;
  logic [63:0]        r_addr;
  logic [63:0]        r_wdata;
  logic [63:0]        r_rdata_q;
  logic               r_err_q;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_pick;
  logic               w_aligned;
  logic               w_last_access;

  // A tie goes to whichever port did not win last time.
  always_comb begin
    w_pick = dbg_req;
    if (cpu_req && dbg_req) begin
      w_pick = !r_last_grant;
    end
  end

  assign w_aligned     = (r_addr[2:0] == 3'b000);
  assign w_last_access = (r_state == ACCESS) && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata_q    <= '0;
      r_err_q      <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu_req || dbg_req) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_we         <= w_pick ? dbg_we    : cpu_we;
            r_addr       <= w_pick ? dbg_addr  : cpu_addr;
            r_wdata      <= w_pick ? dbg_wdata : cpu_wdata;
            r_cnt        <= CNT_W'(LATENCY - 1);
            r_state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            r_rdata_q <= w_aligned ? mem_rdata : 64'd0;
            r_err_q   <= !w_aligned;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // The write strobe is gated by reset so a store caught by reset is aborted.
  assign mem_we        = r_we && w_last_access && w_aligned && !reset;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign mem_xfer_size = 4'b1000;

  assign cpu_rdata = r_rdata_q;
  assign dbg_rdata = r_rdata_q;
  assign cpu_err   = r_err_q;
  assign dbg_err   = r_err_q;
  assign dbg_ack   = (r_state == DONE) && r_grant;
  assign cpu_stall = cpu_req && !((r_state == DONE) && !r_grant);

endmodule
